// File: rtl/ascii_pkg.sv
// Shared ASCII constants, address width and dump FSM state encoding.
// DUMP_LABEL_EN adds the LABEL state and the "xNN: " row-prefix helpers.
package ascii_pkg;

  localparam int         ADDR_W        = 13;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;

`ifdef DUMP_LABEL_EN
  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [4:0] LABEL_LAST  = 5'd4;

  typedef enum logic [2:0] {IDLE, READ, LATCH, LABEL, HEX, FINISH} dump_state_t;

  // Character pos (0..4) of the "xNN: " prefix for register idx.
  function automatic logic [7:0] label_char(input logic [4:0] idx, input logic [4:0] pos);
    case (pos)
      5'd0:    label_char = ASCII_X;
      5'd1:    label_char = ASCII_ZERO + {3'b000, idx / 5'd10};
      5'd2:    label_char = ASCII_ZERO + {3'b000, idx % 5'd10};
      5'd3:    label_char = ASCII_COLON;
      default: label_char = ASCII_SPACE;
    endcase
  endfunction
`else
  typedef enum logic [2:0] {IDLE, READ, LATCH, HEX, FINISH} dump_state_t;
`endif

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase hex ASCII digit.
module nibble_to_ascii
  import ascii_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_ZERO + {4'h0, nibble};
    else                ascii = ASCII_UPPER_A + {4'h0, nibble} - 8'd10;
  end

endmodule

// File: rtl/hex_dump_engine.sv
// Dumps NUM_REGS debug registers as hex text rows into a character buffer.
// Define DUMP_LABEL_EN to prefix each row with "xNN: ".
//
// state  | meaning
// IDLE   | waiting for start
// READ   | debug_reg = index presented to the register file
// LATCH  | register value captured, first character staged
// LABEL  | emitting the 5-character row prefix (DUMP_LABEL_EN only)
// HEX    | emitting hex digits, most significant nibble first
// FINISH | last row written; done pulses in the following cycle
module hex_dump_engine
  import ascii_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int COLS      = 80,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           debug_reg,
  input  logic [WORD_SIZE-1:0] debug_reg_out,
  output logic                 ascii_write_en,
  output logic [ADDR_W-1:0]    ascii_write_address,
  output logic [7:0]           ascii_input,
  input  logic                 ascii_ready
);

  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(COLS);
  localparam logic [4:0]        LAST_DIGIT = 5'(WORD_SIZE / 4 - 1);
  localparam logic [4:0]        LAST_REG   = 5'(NUM_REGS - 1);

  dump_state_t            state;
  logic [4:0]             idx;
  logic [4:0]             col;
  logic [WORD_SIZE-1:0]   sreg;
  logic [ADDR_W-1:0]      row_base;
  logic [3:0]             nib;
  logic [7:0]             hex_char;
  logic                   xfer;

  assign xfer = ascii_write_en & ascii_ready;

  // Nibble for the character staged next: the register's top nibble when a
  // row's digits begin, otherwise the one below the digit now on the bus.
  always_comb begin
    nib = sreg[WORD_SIZE-5 -: 4];
    if (state == LATCH) nib = debug_reg_out[WORD_SIZE-1 -: 4];
`ifdef DUMP_LABEL_EN
    else if (state == LABEL) nib = sreg[WORD_SIZE-1 -: 4];
`endif
  end

  nibble_to_ascii u_nib (
    .nibble (nib),
    .ascii  (hex_char)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      idx                 <= '0;
      col                 <= '0;
      sreg                <= '0;
      row_base            <= BASE;
      busy                <= 1'b0;
      done                <= 1'b0;
      debug_reg           <= '0;
      ascii_write_en      <= 1'b0;
      ascii_write_address <= '0;
      ascii_input         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            idx       <= '0;
            debug_reg <= '0;
            row_base  <= BASE;
            busy      <= 1'b1;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          sreg                <= debug_reg_out;
          col                 <= '0;
          ascii_write_en      <= 1'b1;
          ascii_write_address <= row_base;
`ifdef DUMP_LABEL_EN
          state               <= LABEL;
          ascii_input         <= label_char(idx, 5'd0);
`else
          state               <= HEX;
          ascii_input         <= hex_char;
`endif
        end
`ifdef DUMP_LABEL_EN
        LABEL: begin
          if (xfer) begin
            ascii_write_address <= ascii_write_address + 1'b1;
            if (col == LABEL_LAST) begin
              state       <= HEX;
              col         <= '0;
              ascii_input <= hex_char;
            end else begin
              col         <= col + 5'd1;
              ascii_input <= label_char(idx, col + 5'd1);
            end
          end
        end
`endif
        HEX: begin
          if (xfer) begin
            if (col == LAST_DIGIT) begin
              ascii_write_en <= 1'b0;
              if (idx == LAST_REG) begin
                state <= FINISH;
              end else begin
                state     <= READ;
                idx       <= idx + 5'd1;
                debug_reg <= idx + 5'd1;
                row_base  <= row_base + ROW_STEP;
              end
            end else begin
              col                 <= col + 5'd1;
              ascii_write_address <= ascii_write_address + 1'b1;
              sreg                <= sreg << 4;
              ascii_input         <= hex_char;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
